// File: rtl/execute_cc_mreg.sv
// Y86-64 execute back half: condition codes, cmov squash
// and the E->M pipeline register with stall/bubble control.
//
// Ports:
//   clk, rst        rising-edge clock, sync active-high reset
//   E_*             instruction fields sitting in E
//   e_valE, alu_cf  ALU result and its {OF,SF,ZF} flags
//   m_stat, W_stat  downstream status, gates cc updates
//   M_stall/bubble  M register hold / nop insert
//   cc              current {OF,SF,ZF}
//   e_Cnd, e_dstE   combinational condition and squashed dstE
//   M_*             registered M-stage copies
module execute_cc_mreg #(
  parameter int         WIDTH = 64,
  parameter logic [3:0] RNONE = 4'hF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       E_stat,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_ifun,
  input  logic [WIDTH-1:0] e_valE,
  input  logic [2:0]       alu_cf,
  input  logic [WIDTH-1:0] E_valA,
  input  logic [3:0]       E_dstE,
  input  logic [3:0]       E_dstM,
  input  logic [2:0]       m_stat,
  input  logic [2:0]       W_stat,
  input  logic             M_stall,
  input  logic             M_bubble,
  output logic [2:0]       cc,
  output logic             e_Cnd,
  output logic [3:0]       e_dstE,
  output logic [2:0]       M_stat,
  output logic [3:0]       M_icode,
  output logic             M_Cnd,
  output logic [WIDTH-1:0] M_valE,
  output logic [WIDTH-1:0] M_valA,
  output logic [3:0]       M_dstE,
  output logic [3:0]       M_dstM
);

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [3:0] I_NOP = 4'd1;
  localparam logic [3:0] I_CMOV = 4'd2;
  localparam logic [3:0] I_OPQ = 4'd6;

  logic [2:0]       cc_q, cc_d;
  logic [2:0]       stat_q, stat_d;
  logic [3:0]       icode_q, icode_d;
  logic             cnd_q, cnd_d;
  logic [WIDTH-1:0] vale_q, vale_d;
  logic [WIDTH-1:0] vala_q, vala_d;
  logic [3:0]       dste_q, dste_d;
  logic [3:0]       dstm_q, dstm_d;

  logic set_cc;
  logic of_f, sf_f, zf_f, lt;

  assign of_f = cc_q[2];
  assign sf_f = cc_q[1];
  assign zf_f = cc_q[0];
  assign lt   = sf_f ^ of_f;

  // Downstream exceptions freeze cc so a faulting
  // instruction's successors cannot disturb it.
  assign set_cc = (E_icode == I_OPQ) &&
                  (m_stat == S_AOK) &&
                  (W_stat == S_AOK);

  always_comb begin
    e_Cnd = 1'b0;
    unique case (E_ifun)
      4'd0:    e_Cnd = 1'b1;
      4'd1:    e_Cnd = lt | zf_f;
      4'd2:    e_Cnd = lt;
      4'd3:    e_Cnd = zf_f;
      4'd4:    e_Cnd = ~zf_f;
      4'd5:    e_Cnd = ~lt;
      4'd6:    e_Cnd = ~lt & ~zf_f;
      default: e_Cnd = 1'b0;
    endcase
  end

  assign e_dstE = (E_icode == I_CMOV && !e_Cnd) ?
                  RNONE : E_dstE;

  always_comb begin
    cc_d    = set_cc ? alu_cf : cc_q;
    stat_d  = stat_q;
    icode_d = icode_q;
    cnd_d   = cnd_q;
    vale_d  = vale_q;
    vala_d  = vala_q;
    dste_d  = dste_q;
    dstm_d  = dstm_q;
    if (M_bubble) begin
      stat_d  = S_AOK;
      icode_d = I_NOP;
      cnd_d   = 1'b0;
      vale_d  = '0;
      vala_d  = '0;
      dste_d  = RNONE;
      dstm_d  = RNONE;
    end else if (!M_stall) begin
      stat_d  = E_stat;
      icode_d = E_icode;
      cnd_d   = e_Cnd;
      vale_d  = e_valE;
      vala_d  = E_valA;
      dste_d  = e_dstE;
      dstm_d  = E_dstM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cc_q    <= 3'b001;
      stat_q  <= S_AOK;
      icode_q <= I_NOP;
      cnd_q   <= 1'b0;
      vale_q  <= '0;
      vala_q  <= '0;
      dste_q  <= RNONE;
      dstm_q  <= RNONE;
    end else begin
      cc_q    <= cc_d;
      stat_q  <= stat_d;
      icode_q <= icode_d;
      cnd_q   <= cnd_d;
      vale_q  <= vale_d;
      vala_q  <= vala_d;
      dste_q  <= dste_d;
      dstm_q  <= dstm_d;
    end
  end

  assign cc      = cc_q;
  assign M_stat  = stat_q;
  assign M_icode = icode_q;
  assign M_Cnd   = cnd_q;
  assign M_valE  = vale_q;
  assign M_valA  = vala_q;
  assign M_dstE  = dste_q;
  assign M_dstM  = dstm_q;

endmodule
